// File: rtl/util_sdio_xfer.sv
`default_nettype none
// ============================================================================
// Module   : util_sdio_xfer
// Brief    : Half-duplex 3-wire SPI master (shared SDIO) running one 24-bit
//            instruction+data transaction per request. Optional csn gap is
//            enabled by defining UTIL_SDIO_XFER_CSN_GAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module util_sdio_xfer #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        up_req,
    input  logic        up_rnw,
    input  logic [12:0] up_addr,
    input  logic [7:0]  up_wdata,
    output logic        up_ready,
    output logic        up_ack,
    output logic [7:0]  up_rdata,
    output logic        spi_csn,
    output logic        spi_clk,
    output logic        sdio_i,
    output logic        sdio_t,
    input  logic        sdio_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_HOLD  = 3'd4,
        ST_DONE  = 3'd5,
        ST_GAP   = 3'd6
    } state_t;

    localparam logic [8:0] DIV_LAST = 9'(CLK_DIV - 1);
`ifdef UTIL_SDIO_XFER_CSN_GAP_EN
    localparam logic [8:0] GAP_LAST = 9'(2 * CLK_DIV - 1);
`endif

    state_t      state_q, state_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [4:0]  bit_q, bit_d;
    logic [23:0] shift_q, shift_d;
    logic [7:0]  rx_q, rx_d;
    logic        rnw_q, rnw_d;

    logic        ready_q, ready_d;
    logic        ack_q, ack_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        csn_q, csn_d;
    logic        sclk_q, sclk_d;
    logic        sdi_q, sdi_d;
    logic        sdt_q, sdt_d;

    logic        w_last;
    logic        w_active;
    logic        w_release;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        rx_d    = rx_q;
        rnw_d   = rnw_q;
        w_last  = (cnt_q == DIV_LAST);

        case (state_q)
            ST_IDLE: begin
                if (up_req && ready_q) begin
                    state_d = ST_SETUP;
                    cnt_d   = 9'd0;
                    bit_d   = 5'd23;
                    rnw_d   = up_rnw;
                    shift_d = {up_rnw, 2'b00, up_addr, (up_rnw ? 8'h00 : up_wdata)};
                end
            end
            ST_SETUP: begin
                if (w_last) begin
                    state_d = ST_HIGH;
                    cnt_d   = 9'd0;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            ST_HIGH: begin
                if (w_last) begin
                    cnt_d = 9'd0;
                    // Sample on the edge that ends HIGH (SCLK falling edge)
                    if (rnw_q && (bit_q < 5'd8)) begin
                        rx_d = {rx_q[6:0], sdio_o};
                    end
                    if (bit_q == 5'd0) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_LOW;
                        bit_d   = bit_q - 5'd1;
                        shift_d = {shift_q[22:0], 1'b0};
                    end
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            ST_LOW: begin
                if (w_last) begin
                    state_d = ST_HIGH;
                    cnt_d   = 9'd0;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            ST_HOLD: begin
                if (w_last) begin
                    state_d = ST_DONE;
                    cnt_d   = 9'd0;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            ST_DONE: begin
`ifdef UTIL_SDIO_XFER_CSN_GAP_EN
                state_d = ST_GAP;
                cnt_d   = 9'd0;
`else
                state_d = ST_IDLE;
`endif
            end
`ifdef UTIL_SDIO_XFER_CSN_GAP_EN
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = 9'd0;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 9'd0;
            end
        endcase

        // Outputs are derived from next-state values so every pin is a flop
        w_active  = (state_d == ST_SETUP) || (state_d == ST_HIGH) ||
                    (state_d == ST_LOW)   || (state_d == ST_HOLD);
        w_release = rnw_d && (bit_d < 5'd8);

        csn_d   = !w_active;
        sclk_d  = (state_d == ST_HIGH);
        sdt_d   = !w_active || w_release;
        sdi_d   = sdt_d ? 1'b0 : shift_d[23];
        ready_d = (state_d == ST_IDLE);
        ack_d   = (state_d == ST_DONE);
        rdata_d = ((state_d == ST_DONE) && rnw_q) ? rx_d : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 9'd0;
            bit_q   <= 5'd0;
            shift_q <= 24'd0;
            rx_q    <= 8'd0;
            rnw_q   <= 1'b0;
            ready_q <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= 8'd0;
            csn_q   <= 1'b1;
            sclk_q  <= 1'b0;
            sdi_q   <= 1'b0;
            sdt_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            rx_q    <= rx_d;
            rnw_q   <= rnw_d;
            ready_q <= ready_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            csn_q   <= csn_d;
            sclk_q  <= sclk_d;
            sdi_q   <= sdi_d;
            sdt_q   <= sdt_d;
        end
    end

    assign up_ready = ready_q;
    assign up_ack   = ack_q;
    assign up_rdata = rdata_q;
    assign spi_csn  = csn_q;
    assign spi_clk  = sclk_q;
    assign sdio_i   = sdi_q;
    assign sdio_t   = sdt_q;

endmodule
`default_nettype wire

// File: tb/tb_util_sdio_xfer.sv
`default_nettype none
// ============================================================================
// Module   : tb_util_sdio_xfer
// Brief    : Self-checking bench for util_sdio_xfer (CLK_DIV=4 and CLK_DIV=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_util_sdio_xfer;

    logic        clk;
    logic        rst;
    logic        req;
    logic        rnw;
    logic [12:0] addr;
    logic [7:0]  wdata;
    logic        sel;
    logic        slv;

    logic        rdy4, ack4, csn4, sck4, si4, st4;
    logic [7:0]  rd4;
    logic        rdy2, ack2, csn2, sck2, si2, st2;
    logic [7:0]  rd2;
    logic        so4, so2, req4, req2;

    assign req4 = req & ~sel;
    assign req2 = req & sel;
    // Pad model: slave drives only while the master has released the line
    assign so4  = st4 ? slv : si4;
    assign so2  = st2 ? slv : si2;

    util_sdio_xfer #(.CLK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .up_req(req4), .up_rnw(rnw), .up_addr(addr),
        .up_wdata(wdata), .up_ready(rdy4), .up_ack(ack4), .up_rdata(rd4),
        .spi_csn(csn4), .spi_clk(sck4), .sdio_i(si4), .sdio_t(st4), .sdio_o(so4)
    );

    util_sdio_xfer #(.CLK_DIV(2)) dut2 (
        .clk(clk), .rst(rst), .up_req(req2), .up_rnw(rnw), .up_addr(addr),
        .up_wdata(wdata), .up_ready(rdy2), .up_ack(ack2), .up_rdata(rd2),
        .spi_csn(csn2), .spi_clk(sck2), .sdio_i(si2), .sdio_t(st2), .sdio_o(so2)
    );

    logic       m_rdy, m_ack, m_csn, m_sck, m_si, m_st;
    logic [7:0] m_rd;
    assign m_rdy = sel ? rdy2 : rdy4;
    assign m_ack = sel ? ack2 : ack4;
    assign m_csn = sel ? csn2 : csn4;
    assign m_sck = sel ? sck2 : sck4;
    assign m_si  = sel ? si2  : si4;
    assign m_st  = sel ? st2  : st4;
    assign m_rd  = sel ? rd2  : rd4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rnw;
        logic [12:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  sd;
        logic [23:0] word;
        logic [7:0]  rdata;
    } vec_t;

    int errors = 0;
    int checks = 0;

    int          cyc, rises, falls, t_err, i_err, ack_cyc, rdy_cyc, ack_n;
    int          first_rise, second_rise, rise_cyc, csn_falls, bad_acc, gap_min;
    logic [23:0] word;
    logic        prev_sck, prev_si, prev_csn, prev_rdy, cur_rnw, ack_csn;
    logic [7:0]  cur_sd, ack_rd;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic mon_reset();
        rises = 0; falls = 0; word = 24'd0; t_err = 0; i_err = 0;
        ack_cyc = -1; rdy_cyc = -1; ack_n = 0; first_rise = -1; second_rise = -1;
        rise_cyc = -1; csn_falls = 0; bad_acc = 0; gap_min = 1000000;
        ack_csn = 1'b0; ack_rd = 8'd0; slv = 1'b0;
        prev_sck = m_sck; prev_si = m_si; prev_csn = m_csn; prev_rdy = m_rdy;
    endtask

    // Advance one clock, sample #1 after the edge and update the bus monitor
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (m_sck && !prev_sck) begin
            word = {word[22:0], m_si};
            rises++;
            if (rises == 1) first_rise = cyc;
            if (rises == 2) second_rise = cyc;
        end
        if (!m_sck && prev_sck) begin
            falls++;
            if (falls >= 16 && falls <= 23) slv = cur_sd[3'(23 - falls)];
        end
        if (m_sck && (m_si != prev_si)) i_err++;
        if (!m_csn && (m_st != (cur_rnw && falls >= 16))) t_err++;
        if (m_ack) begin
            ack_n++;
            if (ack_cyc < 0) begin
                ack_cyc = cyc; ack_rd = m_rd; ack_csn = m_csn;
            end
        end
        if (m_rdy && ack_cyc >= 0 && rdy_cyc < 0) rdy_cyc = cyc;
        if (m_csn && !prev_csn) rise_cyc = cyc;
        if (!m_csn && prev_csn) begin
            csn_falls++;
            if (!prev_rdy) bad_acc++;
            if (rise_cyc >= 0 && (cyc - rise_cyc) < gap_min) gap_min = cyc - rise_cyc;
        end
        prev_sck = m_sck; prev_si = m_si; prev_csn = m_csn; prev_rdy = m_rdy;
    endtask

    function automatic int exp_ready(input int d);
`ifdef UTIL_SDIO_XFER_CSN_GAP_EN
        return 51 * d + 2;
`else
        return 49 * d + 2;
`endif
    endfunction

    task automatic start_req(input vec_t v);
        int w;
        w = 0;
        while (!m_rdy && w < 1000) begin
            step();
            w++;
        end
        chk("ready_before_req", int'(m_rdy), 1);
        mon_reset();
        cur_rnw = v.rnw; cur_sd = v.sd;
        rnw = v.rnw; addr = v.addr; wdata = v.wdata; req = 1'b1;
        cyc = 0;
        step();
        req = 1'b0;
        // Scramble inputs after accept; they must not affect the transfer
        rnw = ~v.rnw; addr = ~v.addr; wdata = ~v.wdata;
    endtask

    task automatic run_xfer(input string nm, input vec_t v, input int d);
        start_req(v);
        while (rdy_cyc < 0 && cyc < 3000) step();
        chk({nm, "_word"},   int'(word), int'(v.word));
        chk({nm, "_edges"},  rises, 24);
        chk({nm, "_ack_cyc"}, ack_cyc, 49 * d + 1);
        chk({nm, "_rdy_cyc"}, rdy_cyc, exp_ready(d));
        chk({nm, "_rdata"},  int'(ack_rd), int'(v.rdata));
        chk({nm, "_csn_at_ack"}, int'(ack_csn), 1);
        chk({nm, "_sdio_t"}, t_err, 0);
        chk({nm, "_sdio_i_stable"}, i_err, 0);
    endtask

    vec_t vecs[5];
    vec_t v;

    initial begin
        vecs[0] = '{rnw: 1'b0, addr: 13'h0037, wdata: 8'hA5, sd: 8'h00, word: 24'h0037A5, rdata: 8'h00};
        vecs[1] = '{rnw: 1'b1, addr: 13'h1FFF, wdata: 8'h77, sd: 8'h3C, word: 24'h9FFF00, rdata: 8'h3C};
        vecs[2] = '{rnw: 1'b0, addr: 13'h1ABC, wdata: 8'h5A, sd: 8'h00, word: 24'h1ABC5A, rdata: 8'h3C};
        vecs[3] = '{rnw: 1'b1, addr: 13'h0001, wdata: 8'h00, sd: 8'hC3, word: 24'h800100, rdata: 8'hC3};
        vecs[4] = '{rnw: 1'b0, addr: 13'h1FFF, wdata: 8'h00, sd: 8'h00, word: 24'h1FFF00, rdata: 8'hC3};

        rst = 1'b1; req = 1'b0; sel = 1'b0; slv = 1'b0; rnw = 1'b0;
        addr = 13'd0; wdata = 8'd0; cur_rnw = 1'b0; cur_sd = 8'd0; cyc = 0;
        step(); step(); step();
        chk("rst_ready", int'(rdy4), 0);
        chk("rst_pins",  int'({csn4, sck4, si4, st4, ack4}), int'(5'b10010));
        chk("rst_rdata", int'(rd4), 0);
        chk("rst_pins_div2", int'({rdy2, csn2, sck2, si2, st2, ack2}), int'(6'b010010));
        rst = 1'b0;
        step();
        chk("ready_after_rst", int'(rdy4), 1);

        for (int i = 0; i < 5; i++) begin
            run_xfer($sformatf("vec%0d", i), vecs[i], 4);
            chk($sformatf("vec%0d_rdata_held", i), int'(rd4), int'(vecs[i].rdata));
        end

        // Back-to-back: request held high across three transactions
        mon_reset();
        cur_rnw = 1'b0; cur_sd = 8'h00;
        rnw = 1'b0; addr = 13'h0123; wdata = 8'h42; req = 1'b1;
        cyc = 0;
        while (!(ack_n == 3 && m_rdy) && cyc < 3000) begin
            step();
            if (csn_falls >= 3) req = 1'b0;
        end
        req = 1'b0;
        chk("b2b_acks", ack_n, 3);
        chk("b2b_csn_falls", csn_falls, 3);
        chk("b2b_accept_only_ready", bad_acc, 0);
        chk("b2b_edges", rises, 72);
`ifdef UTIL_SDIO_XFER_CSN_GAP_EN
        chk("b2b_csn_gap", gap_min, 2 * 4 + 2);
`else
        chk("b2b_csn_gap", gap_min, 2);
`endif
        chk("b2b_sdio_t", t_err, 0);

        // Reset in the middle of a read
        v = '{rnw: 1'b1, addr: 13'h00AA, wdata: 8'h00, sd: 8'h99, word: 24'h0, rdata: 8'h0};
        start_req(v);
        while (cyc < 60) step();
        chk("midrst_busy", int'(m_csn), 0);
        rst = 1'b1;
        step();
        chk("midrst_pins", int'({m_csn, m_st, m_sck, m_ack, m_rdy}), int'(5'b11000));
        chk("midrst_rdata", int'(m_rd), 0);
        rst = 1'b0;
        ack_n = 0;
        for (int i = 0; i < 300; i++) step();
        chk("midrst_no_ack", ack_n, 0);
        chk("midrst_idle_ready", int'(m_rdy), 1);
        v = '{rnw: 1'b1, addr: 13'h0555, wdata: 8'h00, sd: 8'h81, word: 24'h855500, rdata: 8'h81};
        run_xfer("post_rst", v, 4);

        // CLK_DIV=2 write
        sel = 1'b1;
        step();
        v = '{rnw: 1'b0, addr: 13'h0100, wdata: 8'hFF, sd: 8'h00, word: 24'h0100FF, rdata: 8'h00};
        run_xfer("div2", v, 2);
        chk("div2_sclk_period", second_rise - first_rise, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/util_sdio_xfer.md
# util_sdio_xfer

Half-duplex 3-wire SPI (shared SDIO line) master for converter register access. It sits directly upstream of the tristate I/O buffer: it drives the buffer's data-in and tristate-enable per pad and consumes the buffer's data-out. One 24-bit transaction is run per request: a 16-bit instruction followed by 8 data bits. On reads it releases the SDIO line for the data phase and captures the slave's response.

## Interface
Parameters:
- CLK_DIV, 4: SCLK half-period in clk cycles; legal range 2..255.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- up_req  input  1  transaction request; accepted when up_req && up_ready.
- up_rnw  input  1  1 = read, 0 = write; latched at accept.
- up_addr  input  13  register address; latched at accept.
- up_wdata  input  8  write data; latched at accept, ignored on reads.
- up_ready  output  1  engine idle, request can be accepted.
- up_ack  output  1  one-cycle pulse at transaction end.
- up_rdata  output  8  read data; valid from up_ack, held until next read's ack.
- spi_csn  output  1  chip select, active low.
- spi_clk  output  1  SCLK, idle low (mode 0).
- sdio_i  output  1  to buffer I; serial data driven by master.
- sdio_t  output  1  to buffer T; 1 = line released (high-Z).
- sdio_o  input  1  from buffer O; pad value.

## Operation
- Shift word, MSB first, bit 23..0: {up_rnw, 2'b00, up_addr[12:0], data[7:0]}. Data = up_wdata on writes, 8'h00 on reads.
- States: IDLE, SETUP, HIGH, LOW, HOLD, DONE; plus GAP under macro.
- IDLE: csn=1, clk=0, sdio_t=1, up_ready=1. On accept: latch inputs, load shift register, go to SETUP.
- SETUP (CLK_DIV cycles): csn=0, sdio_t=0, sdio_i=bit 23, clk=0. Then go to HIGH.
- HIGH (CLK_DIV cycles): clk=1. On the last HIGH cycle of a data-phase bit (7..0) of a read, shift sdio_o into the rdata shift register. After bit 0, go to HOLD; else go to LOW.
- LOW (CLK_DIV cycles): clk=0. Advance to the next bit on the first LOW cycle. Read turnaround: from the first LOW cycle after bit 8's HIGH, sdio_t=1 until DONE; sdio_i=0 while released.
- HOLD (CLK_DIV cycles): csn=0, clk=0. Then go to DONE.
- DONE (1 cycle): csn=1, sdio_t=1, up_ack=1, up_rdata updated on reads only. Next state is IDLE, or GAP under macro.
- up_req while up_ready=0 is ignored, not queued. Input changes after accept have no effect.
- Writes never release the line before DONE.
- rst at any time: next cycle is IDLE state with reset outputs. No up_ack is issued; up_rdata is cleared.

## Timing
- Reset values: up_ready=0 during rst, 1 on the first cycle after rst deasserts. spi_csn=1, spi_clk=0, sdio_i=0, sdio_t=1, up_ack=0, up_rdata=8'h00.
- All outputs are registered.
- Accept at cycle 0 → csn low during cycles 1..49*CLK_DIV → DONE/up_ack at cycle 49*CLK_DIV+1 → up_ready=1 at cycle 49*CLK_DIV+2 without macro.
- Exactly 24 SCLK rising edges per transaction.
- sdio_i changes only while clk=0; its setup to each rising edge is CLK_DIV cycles.
- Read sample point is the clk edge that ends HIGH, i.e. simultaneous with the SCLK falling edge.

## Configuration
- UTIL_SDIO_XFER_CSN_GAP_EN defined: DONE enters GAP, which holds csn=1, clk=0, sdio_t=1 and up_ready=0 for 2*CLK_DIV cycles before IDLE. up_ready rises at cycle 51*CLK_DIV+2.
- Undefined: no GAP state; DONE goes straight to IDLE.

## Test plan
- Write, CLK_DIV=4, addr 13'h0037, wdata 8'hA5 → SDIO bits sampled on SCLK rising edges = 24'h0037A5. Exactly 24 edges. sdio_t=0 throughout csn low. up_ack at cycle 197; up_ready at 198.
- Read, addr 13'h1FFF, slave model drives 8'h3C after the 16th falling edge → instruction 16'h9FFF on the line. sdio_t=1 from the falling edge after bit 8. up_rdata=8'h3C at up_ack.
- Back-to-back: up_req held high for 3 requests → each accepted only when up_ready=1. No dropped or merged transactions; csn deasserts between them.
- rst asserted mid-shift, at cycle 60 of a read → next cycle csn=1, sdio_t=1, clk=0, up_ack never pulses, up_rdata=0. A new request after rst completes normally.
- CLK_DIV=2, write 8'hFF → SCLK period 4 clk cycles; ack at cycle 99.
- UTIL_SDIO_XFER_CSN_GAP_EN defined, CLK_DIV=4 → up_ready low for 8 extra cycles after up_ack; the next csn falls no earlier than 9 cycles after the previous csn rise.
